score_keeper: RTL

//  Downstream of the per-lane note droppers. Turns their hit/miss level flags into one game score.
//  - Detects the rising edge of each lane flag.
//  - Counts the new hits in each frame.
//  - Keeps a saturating score, a current combo, the best combo and a hit total.
//  - Runs the round state machine: IDLE, PLAY, DONE.

---
 rtl/score_keeper_if.sv | 24 ++
 rtl/score_keeper.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/score_keeper_if.sv
// Bus between the game logic and the score keeper: key/lane flags in, score and round status out.
interface score_keeper_if #(
  parameter int N_LANES = 25
);
  logic [7:0]         keycode;
  logic [N_LANES-1:0] hit_vec;
  logic [N_LANES-1:0] miss_vec;
  logic [13:0]        score;
  logic [7:0]         combo;
  logic [7:0]         max_combo;
  logic [7:0]         hits_total;
  logic               game_active;
  logic               game_over;

  modport master (
    output keycode, hit_vec, miss_vec,
    input  score, combo, max_combo, hits_total, game_active, game_over
  );

  modport slave (
    input  keycode, hit_vec, miss_vec,
    output score, combo, max_combo, hits_total, game_active, game_over
  );
endinterface

// File: rtl/score_keeper.sv
// Frame-rate score keeper: lane hit/miss edges -> saturating score, combo, best combo, hit total, round FSM.
// Optional macro COMBO_BONUS_EN doubles the value of each hit while the combo is at or above COMBO_THRESH.
module score_keeper #(
  parameter int N_LANES        = 25,
  parameter int POINTS_PER_HIT = 10,
  parameter int SCORE_MAX      = 9999,
  parameter int GAME_FRAMES    = 2400,
  parameter int COMBO_THRESH   = 10
) (
  input  logic           frame_clk,
  input  logic           Reset,
  score_keeper_if.slave  bus
);

  localparam int CNT_W   = $clog2(N_LANES + 1);
  localparam int FRAME_W = $clog2(GAME_FRAMES + 1);
  localparam logic [7:0] KEY_START = 8'h2c;
  localparam logic [7:0] KEY_ABORT = 8'h01;

`ifdef COMBO_BONUS_EN
  localparam int BONUS_PTS = POINTS_PER_HIT;
`else
  localparam int BONUS_PTS = 0;
`endif

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t               state_q, state_d;
  logic [N_LANES-1:0]   hit_prev_q, miss_prev_q;
  logic [13:0]          score_q, score_d;
  logic [7:0]           combo_q, combo_d;
  logic [7:0]           max_combo_q, max_combo_d;
  logic [7:0]           hits_total_q, hits_total_d;
  logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                 game_over_q, game_over_d;

  logic [N_LANES-1:0]   new_hit, new_miss;
  logic [CNT_W-1:0]     n_hit;
  logic                 any_miss;
  logic [15:0]          inc, score_sum;
  logic [8:0]           combo_sum, hits_sum;
  logic [13:0]          score_next;
  logic [7:0]           combo_next, max_next, hits_next;

  assign new_hit  = bus.hit_vec & ~hit_prev_q;
  assign new_miss = bus.miss_vec & ~miss_prev_q;
  assign any_miss = |new_miss;

  always_comb begin
    n_hit = '0;
    for (int i = 0; i < N_LANES; i++) begin
      n_hit = n_hit + CNT_W'(new_hit[i]);
    end
  end

  // Candidate PLAY-cycle updates; the bonus term is zero unless the combo bonus is built in
  always_comb begin
    inc = 16'(n_hit) * 16'(POINTS_PER_HIT + ((32'(combo_q) >= COMBO_THRESH) ? BONUS_PTS : 0));
    score_sum  = 16'(score_q) + inc;
    score_next = (score_sum > 16'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];
    combo_sum  = {1'b0, combo_q} + 9'(n_hit);
    if (any_miss) begin
      combo_next = 8'(n_hit);
    end else begin
      combo_next = combo_sum[8] ? 8'hff : combo_sum[7:0];
    end
    max_next  = (combo_next > max_combo_q) ? combo_next : max_combo_q;
    hits_sum  = {1'b0, hits_total_q} + 9'(n_hit);
    hits_next = hits_sum[8] ? 8'hff : hits_sum[7:0];
  end

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    combo_d      = combo_q;
    max_combo_d  = max_combo_q;
    hits_total_d = hits_total_q;
    frame_cnt_d  = frame_cnt_q;
    game_over_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        score_d      = '0;
        combo_d      = '0;
        max_combo_d  = '0;
        hits_total_d = '0;
        frame_cnt_d  = '0;
        if (bus.keycode == KEY_START) state_d = PLAY;
      end
      PLAY: begin
        score_d      = score_next;
        combo_d      = combo_next;
        max_combo_d  = max_next;
        hits_total_d = hits_next;
        frame_cnt_d  = frame_cnt_q + 1'b1;
        // Abort wins over round end and discards this cycle's updates
        if (bus.keycode == KEY_ABORT) begin
          state_d      = IDLE;
          score_d      = '0;
          combo_d      = '0;
          max_combo_d  = '0;
          hits_total_d = '0;
          frame_cnt_d  = '0;
        end else if (frame_cnt_q == FRAME_W'(GAME_FRAMES - 1)) begin
          state_d     = DONE;
          game_over_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.keycode == KEY_ABORT) begin
          state_d      = IDLE;
          score_d      = '0;
          combo_d      = '0;
          max_combo_d  = '0;
          hits_total_d = '0;
          frame_cnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      hit_prev_q   <= '0;
      miss_prev_q  <= '0;
      score_q      <= '0;
      combo_q      <= '0;
      max_combo_q  <= '0;
      hits_total_q <= '0;
      frame_cnt_q  <= '0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hit_prev_q   <= bus.hit_vec;
      miss_prev_q  <= bus.miss_vec;
      score_q      <= score_d;
      combo_q      <= combo_d;
      max_combo_q  <= max_combo_d;
      hits_total_q <= hits_total_d;
      frame_cnt_q  <= frame_cnt_d;
      game_over_q  <= game_over_d;
    end
  end

  assign bus.score       = score_q;
  assign bus.combo       = combo_q;
  assign bus.max_combo   = max_combo_q;
  assign bus.hits_total  = hits_total_q;
  assign bus.game_active = (state_q == PLAY);
  assign bus.game_over   = game_over_q;

endmodule
